fsk_modulator: RTL and testbench
================================

// Module: fsk_modulator
// PURPOSE
//  Binary FSK transmitter: serial data bits in, unsigned 8-bit waveform samples out.
//  Sits at the transmit end of the FSK link, driving the 8-bit sample bus that the FSK demodulator consumes.
//  Each bit becomes one symbol of SYM_LEN clocks: a square-wave tone, mark for '1', space for '0'.
//  Mark levels lie inside 100..200 and space levels lie outside it, so demodulator detection does not depend on phase.
// PARAMETERS
//  SYM_LEN     256    clocks per symbol (>=2*SPACE_HALF)
//  MARK_HALF   8      half-period of mark tone, clocks
//  SPACE_HALF  16     half-period of space tone, clocks
//  MARK_HI     8'hB0  mark high level (176)
//  MARK_LO     8'h70  mark low level (112)
//  SPACE_HI    8'hF0  space high level (240)
//  SPACE_LO    8'h10  space low level (16)
//  IDLE_LEVEL  8'h00  output level when no symbol is being sent
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  bit_in     in   1  data bit to transmit
//  bit_valid  in   1  bit_in is valid
//  bit_ready  out  1  one-entry holding register empty; accept = bit_valid & bit_ready at posedge
//  dout       out  8  registered sample output
//  sym_start  out  1  one-cycle pulse during the first cycle of each symbol on dout
//  busy       out  1  a symbol is being output (state SEND)
// BEHAVIOUR
//  Reset (rst high at posedge): state=IDLE, hold empty, dout=IDLE_LEVEL, sym_start=0, busy=0.
//   bit_ready=0 while rst is high; it is 1 in the first cycle after reset is released.
//   Accepts during rst are ignored. Reset mid-symbol aborts the symbol; no partial symbol is resumed.
//  Handshake: bit_ready = ~hold_full (a direct register output). An accept sets hold_full and stores hold_bit.
//   Accept and consume never happen in the same cycle.
//  FSM, 2 states:
//   IDLE: dout=IDLE_LEVEL. If hold_full: load sym_bit=hold_bit, clear hold, sym_cnt=0, go SEND.
//   SEND: sym_cnt increments each clock, 0..SYM_LEN-1.
//    At sym_cnt==SYM_LEN-1, if hold_full: load the next bit, sym_cnt=0, stay SEND (seamless).
//    At sym_cnt==SYM_LEN-1, if hold is empty: go IDLE, and dout=IDLE_LEVEL on the next cycle.
//  Waveform: at symbol cycle k, with H = sym_bit ? MARK_HALF : SPACE_HALF:
//   dout = ((k/H) even) ? HI : LO, using mark or space levels per sym_bit.
//   Phase restarts at HI on every symbol; there is no phase continuity across symbols.
//  Timing: accept at posedge E -> load at posedge E+1. The new symbol is on dout, with sym_start=1,
//   in the cycle after E+1. Each symbol occupies exactly SYM_LEN cycles.
//   busy=1 for every SEND cycle.
//  Underflow: no bit held at the symbol end -> IDLE. There is no error flag; the gap is IDLE_LEVEL.
//  Counters: sym_cnt is ceil(log2(SYM_LEN)) bits wide. The half-period counter wraps at H-1 and
//   toggles the level there; both counters clear on load.
// TESTING
//  1) Reset, then send bit 1 -> dout is first B0 2 cycles after accept: 8x B0, 8x 70, repeating,
//     for 256 cycles, then 00; busy high for exactly 256 cycles.
//  2) Send bit 0 -> dout is 16x F0, 16x 10, repeating, for 256 cycles; no sample is in 100..200.
//  3) Back-to-back 1,0,1 with bit_valid held high -> sym_start pulses exactly 256 cycles apart, with no
//     IDLE_LEVEL cycle between symbols; bit_ready low while hold is full.
//  4) Feed a second bit 300 cycles after the first -> dout=00 between symbols, busy=0, second sym_start
//     2 cycles after accept.
//  5) Assert rst at symbol cycle 100 -> next cycle dout=00, busy=0, bit_ready=0; the pending hold bit
//     is discarded.
//  6) Loopback into the FSK demodulator with sym_start aligned to its 256-clock window, pattern
//     10110010 -> recovered bits equal the pattern, one symbol later.

Source files
------------

// File: rtl/fsk_modulator.sv
// Binary FSK transmitter: one serial bit per SYM_LEN-clock square-wave symbol,
// mark/space tones on an unsigned 8-bit sample bus, with a one-entry input hold.
module fsk_modulator #(
  parameter int unsigned SYM_LEN    = 256,
  parameter int unsigned MARK_HALF  = 8,
  parameter int unsigned SPACE_HALF = 16,
  parameter logic [7:0]  MARK_HI    = 8'hB0,
  parameter logic [7:0]  MARK_LO    = 8'h70,
  parameter logic [7:0]  SPACE_HI   = 8'hF0,
  parameter logic [7:0]  SPACE_LO   = 8'h10,
  parameter logic [7:0]  IDLE_LEVEL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] dout,
  output logic       sym_start,
  output logic       busy
);

  localparam int unsigned CNT_W    = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int unsigned HALF_MAX = (MARK_HALF > SPACE_HALF) ? MARK_HALF : SPACE_HALF;
  localparam int unsigned HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic              lvl_hi_q, lvl_hi_d;
  logic              sym_bit_q, sym_bit_d;
  logic              hold_full_q, hold_full_d;
  logic              hold_bit_q, hold_bit_d;
  logic              bit_ready_q, bit_ready_d;
  logic [7:0]        dout_q, dout_d;
  logic              sym_start_q, sym_start_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              load;
  logic [HALF_W-1:0] half_last;

  assign accept    = bit_valid & bit_ready_q;
  assign half_last = sym_bit_q ? HALF_W'(MARK_HALF - 1) : HALF_W'(SPACE_HALF - 1);

  // Next-state and registered-output logic; dout_d is the sample for the next symbol cycle.
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    half_cnt_d  = half_cnt_q;
    lvl_hi_d    = lvl_hi_q;
    sym_bit_d   = sym_bit_q;
    hold_full_d = hold_full_q;
    hold_bit_d  = hold_bit_q;
    dout_d      = dout_q;
    sym_start_d = 1'b0;
    busy_d      = busy_q;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        dout_d = IDLE_LEVEL;
        busy_d = 1'b0;
        if (hold_full_q) load = 1'b1;
      end
      S_SEND: begin
        if (sym_cnt_q == CNT_W'(SYM_LEN - 1)) begin
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            dout_d  = IDLE_LEVEL;
            busy_d  = 1'b0;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + CNT_W'(1);
          if (half_cnt_q == half_last) begin
            half_cnt_d = '0;
            lvl_hi_d   = ~lvl_hi_q;
          end else begin
            half_cnt_d = half_cnt_q + HALF_W'(1);
          end
          if (sym_bit_q) dout_d = lvl_hi_d ? MARK_HI : MARK_LO;
          else           dout_d = lvl_hi_d ? SPACE_HI : SPACE_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every symbol starts at its HI level with both counters cleared.
    if (load) begin
      state_d     = S_SEND;
      sym_bit_d   = hold_bit_q;
      hold_full_d = 1'b0;
      sym_cnt_d   = '0;
      half_cnt_d  = '0;
      lvl_hi_d    = 1'b1;
      dout_d      = hold_bit_q ? MARK_HI : SPACE_HI;
      sym_start_d = 1'b1;
      busy_d      = 1'b1;
    end

    if (accept) begin
      hold_full_d = 1'b1;
      hold_bit_d  = bit_in;
    end

    bit_ready_d = ~hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sym_cnt_q   <= '0;
      half_cnt_q  <= '0;
      lvl_hi_q    <= 1'b1;
      sym_bit_q   <= 1'b0;
      hold_full_q <= 1'b0;
      hold_bit_q  <= 1'b0;
      bit_ready_q <= 1'b0;
      dout_q      <= IDLE_LEVEL;
      sym_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      half_cnt_q  <= half_cnt_d;
      lvl_hi_q    <= lvl_hi_d;
      sym_bit_q   <= sym_bit_d;
      hold_full_q <= hold_full_d;
      hold_bit_q  <= hold_bit_d;
      bit_ready_q <= bit_ready_d;
      dout_q      <= dout_d;
      sym_start_q <= sym_start_d;
      busy_q      <= busy_d;
    end
  end

  assign bit_ready = bit_ready_q;
  assign dout      = dout_q;
  assign sym_start = sym_start_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fsk_modulator.sv
// Bench for fsk_modulator: directed scenarios plus random traffic, checked every
// cycle against a symbol-level transmitter model and a windowed band-energy demodulator.
module tb_fsk_modulator;

  localparam int unsigned SYM_LEN = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic [7:0] dout;
  logic       sym_start;
  logic       busy;

  fsk_modulator dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .dout      (dout),
    .sym_start (sym_start),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: symbol in flight (bit, position k) and the one-entry hold.
  logic m_send = 1'b0, m_bit = 1'b0, m_hold = 1'b0, m_hbit = 1'b0, m_ready = 1'b0, m_seam = 1'b0;
  logic m_acc  = 1'b0;
  int   m_k    = 0;
  int   cyc    = 0;
  int   last_start = 0;
  int   win_n = 0, win_mark = 0;
  logic sent_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] wave(input logic b, input int k);
    int h;
    h = b ? 8 : 16;
    if (b) return ((k / h) % 2 == 0) ? 8'hB0 : 8'h70;
    else   return ((k / h) % 2 == 0) ? 8'hF0 : 8'h10;
  endfunction

  // One clock: model advances on posedge, DUT outputs compared on the following negedge.
  task automatic cycle();
    logic acc, b, in_band;
    acc = bit_valid && m_ready && !rst;
    b   = bit_in;
    @(posedge clk);
    if (rst) begin
      m_send = 1'b0; m_hold = 1'b0; m_ready = 1'b0; m_k = 0; m_seam = 1'b0;
      sent_q.delete(); win_n = 0; win_mark = 0;
    end else begin
      m_seam = 1'b0;
      if (m_hold && (!m_send || m_k == SYM_LEN - 1)) begin
        m_seam = m_send;
        m_send = 1'b1; m_bit = m_hbit; m_k = 0; m_hold = 1'b0;
        sent_q.push_back(m_hbit);
      end else if (m_send && m_k == SYM_LEN - 1) begin
        m_send = 1'b0;
      end else if (m_send) begin
        m_k++;
      end
      if (acc) begin m_hold = 1'b1; m_hbit = b; end
      m_ready = !m_hold;
    end
    m_acc = acc;
    cyc++;
    @(negedge clk);
    check("dout", 32'(dout), 32'(m_send ? wave(m_bit, m_k) : 8'h00));
    check("busy", 32'(busy), 32'(m_send));
    check("sym_start", 32'(sym_start), 32'(m_send && m_k == 0));
    check("bit_ready", 32'(bit_ready), 32'(m_ready));
    in_band = (dout >= 8'd100) && (dout <= 8'd200);
    if (m_send) check("band", 32'(in_band), 32'(m_bit));
    if (sym_start && m_seam) check("sym_gap", 32'(cyc - last_start), 32'(SYM_LEN));
    if (sym_start) last_start = cyc;
    // Demodulator: majority of in-band samples over one busy window decides the bit.
    if (busy) begin
      win_n++;
      if (in_band) win_mark++;
      if (win_n == SYM_LEN) begin
        check("loopback_q", 32'(sent_q.size() > 0), 32'd1);
        if (sent_q.size() > 0) check("loopback", 32'(win_mark > SYM_LEN / 2), 32'(sent_q.pop_front()));
        win_n = 0; win_mark = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present a bit until it is accepted; bit_valid stays high on return.
  task automatic send_bit(input logic b);
    int i;
    bit_in = b; bit_valid = 1'b1;
    i = 0;
    do begin cycle(); i++; end while (!m_acc && i < 2000);
    if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] pat;
    int i;
    pat = 8'b10110010;
    rst = 1'b1;
    for (int j = 0; j < 3; j++) cycle();
    rst = 1'b0;
    idle(3);

    send_bit(1'b1); idle(300);
    send_bit(1'b0); idle(300);

    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); idle(800);

    send_bit(1'b1); idle(300);
    send_bit(1'b0); idle(300);

    // Abort mid-symbol with a bit still held.
    send_bit(1'b1); send_bit(1'b0); bit_valid = 1'b0;
    i = 0;
    while (!(m_send && m_k == 100) && i < 600) begin cycle(); i++; end
    if (!(m_send && m_k == 100)) check("rst_wait", 32'd0, 32'd1);
    rst = 1'b1; cycle();
    rst = 1'b0; idle(300);

    for (int j = 7; j >= 0; j--) send_bit(pat[j]);
    idle(300);

    for (int j = 0; j < 4000; j++) begin
      bit_valid = ($urandom_range(0, 999) < ((j / 1000) % 2 == 0 ? 5 : 900));
      bit_in    = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 2999) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(600);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
